// File: rtl/mult_8x8_e_1111.sv
// 8x8 unsigned nibble-decomposed multiplier. Each 4x4 sub-product can be exact
// or approximate; the approximate form ORs the weight-2 column and drops its carry.
module mult_8x8_e_1111 #(
    parameter logic [3:0] APPROX_CFG = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    output logic [15:0] R
);

    function automatic logic [7:0] approx_mul4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] acc;
        acc = 8'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i + j >= 2)
                    acc = acc + (8'(x[i] & y[j]) << (i + j));
            end
        end
        acc = acc + {6'd0, (x[1] & y[0]) | (x[0] & y[1]), x[0] & y[0]};
        return acc;
    endfunction

    function automatic logic [7:0] exact_mul4(input logic [3:0] x, input logic [3:0] y);
        return {4'd0, x} * {4'd0, y};
    endfunction

    function automatic logic [7:0] sub_mul4(input logic [3:0] x, input logic [3:0] y,
                                            input logic approx);
        return approx ? approx_mul4(x, y) : exact_mul4(x, y);
    endfunction

    logic [7:0]  p_ll_p0, p_lh_p0, p_hl_p0, p_hh_p0;
    logic [15:0] s_p0;

    always_comb begin
        p_ll_p0 = sub_mul4(A[3:0], B[3:0], APPROX_CFG[0]);
        p_lh_p0 = sub_mul4(A[3:0], B[7:4], APPROX_CFG[1]);
        p_hl_p0 = sub_mul4(A[7:4], B[3:0], APPROX_CFG[2]);
        p_hh_p0 = sub_mul4(A[7:4], B[7:4], APPROX_CFG[3]);
        s_p0    = {8'd0, p_ll_p0}
                + {4'd0, p_lh_p0, 4'd0}
                + {4'd0, p_hl_p0, 4'd0}
                + {p_hh_p0, 8'd0};
    end

    // p0 -> p1: single output register; R holds while no new operands arrive
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            R         <= 16'h0000;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                R <= s_p0;
        end
    end

endmodule

// File: tb/tb_mult_8x8_e_1111.sv
// Bench for mult_8x8_e_1111: default (all approximate) and all-exact instances
// driven in parallel and compared against an arithmetic reference model.
module tb_mult_8x8_e_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a, b;
    logic        v_apx, v_ex;
    logic [15:0] r_apx, r_ex;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_r_apx, exp_r_ex;
    logic        exp_v;

    always #5 clk = ~clk;

    mult_8x8_e_1111 dut_apx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(v_apx), .R(r_apx)
    );

    mult_8x8_e_1111 #(.APPROX_CFG(4'b0000)) dut_ex (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(v_ex), .R(r_ex)
    );

    // approximate 4x4 product is exact except -2 when both low bit pairs are 11
    function automatic int ref_sub(input int x, input int y, input bit ap);
        return x * y - ((ap && (x % 4 == 3) && (y % 4 == 3)) ? 2 : 0);
    endfunction

    function automatic int ref_mul(input int x, input int y, input logic [3:0] cfg);
        int al, ah, bl, bh;
        al = x % 16; ah = x / 16; bl = y % 16; bh = y / 16;
        return ref_sub(al, bl, cfg[0]) + 16 * ref_sub(al, bh, cfg[1])
             + 16 * ref_sub(ah, bl, cfg[2]) + 256 * ref_sub(ah, bh, cfg[3]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input bit r, input bit v, input int x, input int y);
        rst      = r;
        in_valid = v;
        a        = x[7:0];
        b        = y[7:0];
        if (r) begin
            exp_v     = 1'b0;
            exp_r_apx = 16'h0000;
            exp_r_ex  = 16'h0000;
        end else begin
            exp_v = v;
            if (v) begin
                exp_r_apx = 16'(ref_mul(x % 256, y % 256, 4'b1111));
                exp_r_ex  = 16'(ref_mul(x % 256, y % 256, 4'b0000));
            end
        end
        @(posedge clk);
        #1;
        check("vld_apx", {31'd0, v_apx}, {31'd0, exp_v});
        check("vld_ex",  {31'd0, v_ex},  {31'd0, exp_v});
        check("r_apx",   {16'd0, r_apx}, {16'd0, exp_r_apx});
        check("r_ex",    {16'd0, r_ex},  {16'd0, exp_r_ex});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0;
        apply(1, 0, 0, 0);
        apply(1, 1, 77, 99);
        check("reset_r", {16'd0, r_apx}, 32'd0);
        check("reset_v", {31'd0, v_apx}, 32'd0);

        apply(0, 1, 3, 3);
        check("r_3x3", {16'd0, r_apx}, 32'd7);
        check("r_3x3_ex", {16'd0, r_ex}, 32'd9);
        check("v_3x3", {31'd0, v_apx}, 32'd1);
        apply(0, 1, 255, 255);
        check("r_ffxff", {16'd0, r_apx}, 32'd64447);
        check("r_ffxff_ex", {16'd0, r_ex}, 32'd65025);
        apply(0, 1, 2, 4);
        check("r_2x4", {16'd0, r_apx}, 32'd8);
        apply(0, 1, 16, 16);
        check("r_10x10", {16'd0, r_apx}, 32'd256);
        apply(0, 1, 8'h30, 8'h03);
        check("r_30x03", {16'd0, r_apx}, 32'd112);
        check("r_30x03_ex", {16'd0, r_ex}, 32'd144);

        // streaming then drop valid: R must hold, out_valid must clear
        apply(0, 1, 11, 7);
        apply(0, 1, 200, 13);
        apply(0, 1, 63, 63);
        apply(0, 1, 127, 251);
        apply(0, 0, 1, 1);
        check("hold_r", {16'd0, r_apx}, 32'(ref_mul(127, 251, 4'b1111)));
        apply(0, 0, 5, 9);

        // reset while operands are valid
        apply(0, 1, 99, 99);
        apply(1, 1, 45, 45);
        check("rst_mid_r", {16'd0, r_apx}, 32'd0);
        apply(0, 1, 45, 45);

        // exhaustive sweep
        for (int i = 0; i < 65536; i++)
            apply(0, 1, i / 256, i % 256);

        // random traffic with gaps and occasional resets
        for (int k = 0; k < 3000; k++)
            apply($urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 255), $urandom_range(0, 255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
